// File: rtl/neuron_sequencer_pkg.sv
// Shared types for the neuron sequencer: the sfp fixed-point format (Q4.12),
// the saturation helper, the activation select codes and the sequencer states.
package neuron_sequencer_pkg;

    localparam int SFP_W    = 16;
    localparam int SFP_FRAC = 12;

    typedef logic signed [SFP_W-1:0] sfp;

    localparam sfp SFP_ONE  = sfp'(1 << SFP_FRAC);
    localparam sfp SFP_HALF = sfp'(1 << (SFP_FRAC - 1));
    localparam sfp SFP_MAX  = sfp'((1 << (SFP_W - 1)) - 1);
    localparam sfp SFP_MIN  = sfp'(-(1 << (SFP_W - 1)));

    // Width of the value handed to sat_to_sfp; any accumulator up to this
    // width is sign-extended into it by the caller.
    localparam int SAT_IN_W = 64;

    typedef struct packed {
        sfp   val;
        logic clip;
    } sat_t;

    // Code 2'd3 is deliberately unassigned; Predict maps it to zero.
    typedef enum logic [1:0] {
        ACT_RELU    = 2'd0,
        ACT_STEP    = 2'd1,
        ACT_SIGMOID = 2'd2
    } act_func;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCUM    = 2'd1,
        ACTIVATE = 2'd2,
        OUTPUT   = 2'd3
    } seq_state_e;

    // Clip a wide signed value into the sfp range and report whether it clipped.
    function automatic sat_t sat_to_sfp(input logic signed [SAT_IN_W-1:0] v);
        sat_t r;
        r.clip = 1'b1;
        if (v > SAT_IN_W'(SFP_MAX)) begin
            r.val = SFP_MAX;
        end else if (v < SAT_IN_W'(SFP_MIN)) begin
            r.val = SFP_MIN;
        end else begin
            r.val  = v[SFP_W-1:0];
            r.clip = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/neuron_sequencer_if.sv
// Control, input-pair stream and result stream of one neuron sequencer.
// master = layer controller / producer side, slave = the sequencer.
interface neuron_sequencer_if
    import neuron_sequencer_pkg::*;
#(
    parameter int MAX_INPUTS = 64
);
    localparam int NW = $clog2(MAX_INPUTS + 1);

    logic          start;
    act_func       activation;
    logic [NW-1:0] n_inputs;
    sfp            bias;
    logic          busy;

    logic          in_valid;
    logic          in_ready;
    sfp            in_x;
    sfp            in_w;

    logic          out_valid;
    logic          out_ready;
    sfp            out_pred;
    sfp            out_sum;
    logic          out_sat;

    modport master (
        output start, activation, n_inputs, bias, in_valid, in_x, in_w, out_ready,
        input  busy, in_ready, out_valid, out_pred, out_sum, out_sat
    );

    modport slave (
        input  start, activation, n_inputs, bias, in_valid, in_x, in_w, out_ready,
        output busy, in_ready, out_valid, out_pred, out_sum, out_sat
    );

endinterface

// File: rtl/neuron_sequencer_mac_unit.sv
// Single multiply-accumulate: full-width signed product, arithmetic shift back
// to sfp scale (floor), accumulate into a guarded accumulator; load seeds bias.
module mac_unit
    import neuron_sequencer_pkg::*;
#(
    parameter int ACC_W = SFP_W + 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  sfp                      load_val,
    input  logic                    en,
    input  sfp                      x,
    input  sfp                      w,
    output logic signed [ACC_W-1:0] acc
);
    localparam int PROD_W = 2 * SFP_W;

    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] prod_sh;
    logic signed [ACC_W-1:0]  acc_d;
    logic signed [ACC_W-1:0]  acc_q;

    // Product, rescale and next accumulator value; load wins over accumulate.
    always_comb begin
        prod    = PROD_W'(x) * PROD_W'(w);
        prod_sh = prod >>> SFP_FRAC;
        acc_d   = acc_q;
        if (load) begin
            acc_d = ACC_W'(load_val);
        end else if (en) begin
            acc_d = acc_q + ACC_W'(prod_sh);
        end
    end

    // Accumulator register; wrap inside the guard bits is not detected.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/neuron_sequencer_predict.sv
// Combinational activation stage: ReLU, unit step, and a hard sigmoid
// (x/4 + 0.5 clamped to [0, 1]); unassigned codes produce zero.
module predict
    import neuron_sequencer_pkg::*;
(
    input  act_func func,
    input  sfp      x,
    output sfp      y
);
    sfp hard_sig;

    // Select the activation; x/4 + 0.5 cannot overflow sfp for any sfp x.
    always_comb begin
        hard_sig = (x >>> 2) + SFP_HALF;
        y        = '0;
        case (func)
            ACT_RELU:    y = x[SFP_W-1] ? '0 : x;
            ACT_STEP:    y = x[SFP_W-1] ? '0 : SFP_ONE;
            ACT_SIGMOID: begin
                if (hard_sig[SFP_W-1]) begin
                    y = '0;
                end else if (hard_sig > SFP_ONE) begin
                    y = SFP_ONE;
                end else begin
                    y = hard_sig;
                end
            end
            default:     y = '0;
        endcase
    end

endmodule

// File: rtl/neuron_sequencer.sv
// Sequences one neuron evaluation: latches the job on start, streams n pairs
// through the MAC, saturates acc+bias, activates, and holds the registered
// result on a valid/ready output until it is taken.
module neuron_sequencer
    import neuron_sequencer_pkg::*;
#(
    parameter int MAX_INPUTS = 64,
    parameter int ACC_GUARD  = 8
) (
    input  logic                clk,
    input  logic                rst,
    neuron_sequencer_if.slave   bus
);
    localparam int            NW    = $clog2(MAX_INPUTS + 1);
    localparam int            ACC_W = SFP_W + ACC_GUARD;
    localparam logic [NW-1:0] N_MAX = NW'(MAX_INPUTS);

    seq_state_e              state_d, state_q;
    logic [NW-1:0]           count_d, count_q;
    logic [NW-1:0]           n_d, n_q;
    logic [NW-1:0]           n_clamped;
    act_func                 act_d, act_q;
    sfp                      out_pred_d, out_pred_q;
    sfp                      out_sum_d, out_sum_q;
    logic                    out_sat_d, out_sat_q;
    logic                    beat;
    logic                    mac_load;
    logic signed [ACC_W-1:0] acc;
    sat_t                    sum_sat;
    sfp                      pred;

    assign beat      = bus.in_valid && (state_q == ACCUM);
    assign n_clamped = (bus.n_inputs > N_MAX) ? N_MAX : bus.n_inputs;
    assign sum_sat   = sat_to_sfp(SAT_IN_W'(acc));

    mac_unit #(.ACC_W(ACC_W)) u_mac (
        .clk      (clk),
        .rst      (rst),
        .load     (mac_load),
        .load_val (bus.bias),
        .en       (beat),
        .x        (bus.in_x),
        .w        (bus.in_w),
        .acc      (acc)
    );

    predict u_predict (
        .func (act_q),
        .x    (sum_sat.val),
        .y    (pred)
    );

    // Next-state and datapath register updates; start is only looked at in IDLE.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        n_d        = n_q;
        act_d      = act_q;
        out_pred_d = out_pred_q;
        out_sum_d  = out_sum_q;
        out_sat_d  = out_sat_q;
        mac_load   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mac_load = 1'b1;
                    count_d  = '0;
                    n_d      = n_clamped;
                    act_d    = bus.activation;
                    state_d  = (n_clamped == '0) ? ACTIVATE : ACCUM;
                end
            end
            ACCUM: begin
                if (beat) begin
                    count_d = count_q + NW'(1);
                    if (count_d == n_q) begin
                        state_d = ACTIVATE;
                    end
                end
            end
            ACTIVATE: begin
                out_pred_d = pred;
                out_sum_d  = sum_sat.val;
                out_sat_d  = sum_sat.clip;
                state_d    = OUTPUT;
            end
            OUTPUT: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and result registers; reset abandons any job in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            n_q        <= '0;
            act_q      <= ACT_RELU;
            out_pred_q <= '0;
            out_sum_q  <= '0;
            out_sat_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            n_q        <= n_d;
            act_q      <= act_d;
            out_pred_q <= out_pred_d;
            out_sum_q  <= out_sum_d;
            out_sat_q  <= out_sat_d;
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.in_ready  = (state_q == ACCUM);
    assign bus.out_valid = (state_q == OUTPUT);
    assign bus.out_pred  = out_pred_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_sat   = out_sat_q;

endmodule

// File: tb/tb_neuron_sequencer.sv
// Directed, table-driven bench for neuron_sequencer (sfp = Q4.12).
module tb_neuron_sequencer;
    import neuron_sequencer_pkg::*;

    typedef struct {
        act_func act;
        int      n;
        sfp      bias;
        int      base;
        sfp      exp_sum;
        sfp      exp_pred;
        logic    exp_sat;
    } vec_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    sfp   px [96];
    sfp   pw [96];
    vec_t vecs [12];

    neuron_sequencer_if #(.MAX_INPUTS(64)) bus ();

    neuron_sequencer #(.MAX_INPUTS(64), .ACC_GUARD(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    function automatic vec_t mkv(input act_func a, input int n, input int b, input int base,
                                 input int es, input int ep, input logic s);
        vec_t v;
        v.act      = a;
        v.n        = n;
        v.bias     = sfp'(b);
        v.base     = base;
        v.exp_sum  = sfp'(es);
        v.exp_pred = sfp'(ep);
        v.exp_sat  = s;
        return v;
    endfunction

    // One full job: start, feed pairs whenever in_ready, wait for out_valid,
    // optionally stall the output, then handshake and confirm return to IDLE.
    task automatic run_vec(input string tag, input vec_t v, input bit bub, input int hold,
                           input bit poke);
        int lat;
        int k;
        int neff;
        bit done;
        neff = (v.n > 64) ? 64 : v.n;
        @(negedge clk);
        bus.start      = 1'b1;
        bus.activation = v.act;
        bus.n_inputs   = 7'(v.n);
        bus.bias       = v.bias;
        bus.in_valid   = 1'b0;
        lat  = 0;
        k    = 0;
        done = 1'b0;
        while (!done && lat < 300) begin
            @(negedge clk);
            lat++;
            bus.start = 1'b0;
            if (poke && lat == 3) begin
                bus.start      = 1'b1;
                bus.n_inputs   = 7'd1;
                bus.bias       = 16'sh7000;
                bus.activation = ACT_STEP;
            end
            if (bus.out_valid) begin
                done = 1'b1;
                bus.in_valid = 1'b0;
            end else if (bus.in_ready && k < neff && (!bub || $urandom_range(0, 1) == 1)) begin
                bus.in_valid = 1'b1;
                bus.in_x     = px[v.base + k];
                bus.in_w     = pw[v.base + k];
                k++;
            end else begin
                bus.in_valid = 1'b0;
            end
        end
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        if (!done) begin
            chk({tag, "_timeout"}, 0, 1);
            return;
        end
        if (!bub) chk({tag, "_latency"}, lat, neff + 2);
        chk({tag, "_beats"}, k, neff);
        chk({tag, "_sum"}, int'(bus.out_sum), int'(v.exp_sum));
        chk({tag, "_pred"}, int'(bus.out_pred), int'(v.exp_pred));
        chk({tag, "_sat"}, int'(bus.out_sat), int'(v.exp_sat));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, int'(bus.out_valid), 1);
            chk({tag, "_hold_pred"}, int'(bus.out_pred), int'(v.exp_pred));
            chk({tag, "_hold_sum"}, int'(bus.out_sum), int'(v.exp_sum));
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, "_idle_busy"}, int'(bus.busy), 0);
        chk({tag, "_idle_valid"}, int'(bus.out_valid), 0);
    endtask

    initial begin
        int k;
        int guard;
        n_checks = 0;
        n_errors = 0;

        px[0] = 16'sh1000;  pw[0] = 16'sh2000;
        px[1] = 16'sh0800;  pw[1] = -16'sh1000;
        px[2] = 16'sh3000;  pw[2] = 16'sh0400;
        px[3] = 16'sh0000;  pw[3] = 16'sh0000;
        for (int i = 4; i < 8; i++) begin px[i] = SFP_MAX; pw[i] = SFP_MAX; end
        for (int i = 8; i < 12; i++) begin px[i] = SFP_MAX; pw[i] = SFP_MIN; end
        px[12] = 16'sh0001; pw[12] = -16'sh0001;
        px[13] = 16'sh1000; pw[13] = 16'sh1000;
        px[14] = 16'sh1000; pw[14] = 16'sh1000;
        for (int i = 0; i < 8; i++) begin
            px[15 + i] = sfp'(1024 * (i + 1));
            pw[15 + i] = (i % 2 == 0) ? 16'sh1000 : -16'sh1000;
        end
        px[23] = 16'sh2000; pw[23] = 16'sh0800;
        for (int i = 24; i < 96; i++) begin px[i] = 16'sh0100; pw[i] = 16'sh1000; end

        vecs[0]  = mkv(ACT_RELU,         3,  2048,  0,  11264, 11264, 1'b0);
        vecs[1]  = mkv(ACT_STEP,         0, -1024,  0,  -1024,     0, 1'b0);
        vecs[2]  = mkv(ACT_SIGMOID,      1,     0,  3,      0,  2048, 1'b0);
        vecs[3]  = mkv(ACT_RELU,         4,     0,  4,  32767, 32767, 1'b1);
        vecs[4]  = mkv(ACT_RELU,         4,     0,  8, -32768,     0, 1'b1);
        vecs[5]  = mkv(ACT_RELU,         1,  2048, 12,   2047,  2047, 1'b0);
        vecs[6]  = mkv(act_func'(2'd3),  2,  4096, 13,  12288,     0, 1'b0);
        vecs[7]  = mkv(ACT_SIGMOID,      8,  2048, 15,  -2048,  1536, 1'b0);
        vecs[8]  = mkv(ACT_STEP,         1,     0, 23,   4096,  4096, 1'b0);
        vecs[9]  = mkv(ACT_SIGMOID,      0, 20480,  0,  20480,  4096, 1'b0);
        vecs[10] = mkv(ACT_RELU,         2,     0, 13,   8192,  8192, 1'b0);
        vecs[11] = mkv(ACT_RELU,        70,     0, 24,  16384, 16384, 1'b0);

        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.activation = ACT_RELU;
        bus.n_inputs   = '0;
        bus.bias       = '0;
        bus.in_valid   = 1'b0;
        bus.in_x       = '0;
        bus.in_w       = '0;
        bus.out_ready  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_in_ready", int'(bus.in_ready), 0);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_sat", int'(bus.out_sat), 0);
        chk("rst_out_pred", int'(bus.out_pred), 0);
        chk("rst_out_sum", int'(bus.out_sum), 0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i], 1'b0, (i == 2) ? 10 : 0, 1'b0);
        end

        run_vec("bubbles_poke", vecs[7], 1'b1, 0, 1'b1);

        // Abort a 5-pair job after two beats, then confirm a clean rerun.
        @(negedge clk);
        bus.start      = 1'b1;
        bus.activation = ACT_RELU;
        bus.n_inputs   = 7'd5;
        bus.bias       = 16'sh1000;
        k     = 0;
        guard = 0;
        while (k < 2 && guard < 20) begin
            @(negedge clk);
            guard++;
            bus.start = 1'b0;
            if (bus.in_ready) begin
                bus.in_valid = 1'b1;
                bus.in_x     = 16'sh1000;
                bus.in_w     = 16'sh1000;
                k++;
            end else begin
                bus.in_valid = 1'b0;
            end
        end
        chk("abort_beats", k, 2);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("abort_pre_busy", int'(bus.busy), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_in_ready", int'(bus.in_ready), 0);
        chk("abort_out_valid", int'(bus.out_valid), 0);
        rst = 1'b0;
        run_vec("after_abort", vecs[10], 1'b0, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
